// File: rtl/ram_tdp_arbiter_if.sv
// Request/response bus between client engines and the dual-port RAM arbiter.
// Per-requester fields are packed side by side, requester i at slice i.
interface ram_tdp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_din;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ*DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_din,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_din,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_tdp_arbiter.sv
// Round-robin two-grant arbiter sharing one true-dual-port write-first RAM among NUM_REQ clients.
// Define RAM_TDP_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module ram_tdp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_tdp_arbiter_if.slave  bus,
    output logic              weA,
    output logic              reA,
    output logic              weB,
    output logic              reB,
    output logic [ADDR_W-1:0] addrA,
    output logic [ADDR_W-1:0] addrB,
    output logic [DATA_W-1:0] dinA,
    output logic [DATA_W-1:0] dinB,
    input  logic [DATA_W-1:0] doutA,
    input  logic [DATA_W-1:0] doutB
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0]         w_addr [NUM_REQ];
    logic [DATA_W-1:0]         w_din  [NUM_REQ];
    wire  [NUM_REQ-1:0]        w_rsp_valid;
    wire  [NUM_REQ*DATA_W-1:0] w_rsp_data;

    logic [IDX_W-1:0]   w_start;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_sel_a;
    logic [IDX_W-1:0]   w_sel_b;
    logic               w_hit_a;
    logic               w_hit_b;
    logic [NUM_REQ-1:0] w_grant;

    logic               r_tag1_a_vld;
    logic               r_tag1_b_vld;
    logic               r_tag2_a_vld;
    logic               r_tag2_b_vld;
    logic [IDX_W-1:0]   r_tag1_a_id;
    logic [IDX_W-1:0]   r_tag1_b_id;
    logic [IDX_W-1:0]   r_tag2_a_id;
    logic [IDX_W-1:0]   r_tag2_b_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            wire w_from_a = r_tag2_a_vld && (r_tag2_a_id == IDX_W'(gi));
            wire w_from_b = r_tag2_b_vld && (r_tag2_b_id == IDX_W'(gi));
            assign w_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign w_din[gi]  = bus.req_din[gi*DATA_W +: DATA_W];
            assign w_rsp_valid[gi] = w_from_a | w_from_b;
            assign w_rsp_data[gi*DATA_W +: DATA_W] = w_from_a ? doutA : (w_from_b ? doutB : '0);
        end
    endgenerate

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = w_rsp_data;

`ifdef RAM_TDP_ARB_STRICT_PRIO_EN
    assign w_start = '0;
`else
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_last;

    assign w_start = r_ptr;
    assign w_last  = w_hit_b ? w_sel_b : w_sel_a;

    // Next search starts just past the last requester that won a port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_hit_a) begin
            r_ptr <= (w_last == IDX_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
        end
    end
`endif

    // Port B skips candidates that would touch port A's address when either side writes.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, w_start} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (bus.req_valid[w_idx]) begin
                if (!w_hit_a) begin
                    w_hit_a = 1'b1;
                    w_sel_a = w_idx;
                end else if (!w_hit_b &&
                             !((w_addr[w_idx] == w_addr[w_sel_a]) &&
                               (bus.req_we[w_idx] || bus.req_we[w_sel_a]))) begin
                    w_hit_b = 1'b1;
                    w_sel_b = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_hit_a) w_grant[w_sel_a] = 1'b1;
        if (w_hit_b) w_grant[w_sel_b] = 1'b1;
    end

    assign bus.req_ready = rst_n ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weA          <= 1'b0;
            reA          <= 1'b0;
            weB          <= 1'b0;
            reB          <= 1'b0;
            addrA        <= '0;
            addrB        <= '0;
            dinA         <= '0;
            dinB         <= '0;
            r_tag1_a_vld <= 1'b0;
            r_tag1_b_vld <= 1'b0;
            r_tag2_a_vld <= 1'b0;
            r_tag2_b_vld <= 1'b0;
            r_tag1_a_id  <= '0;
            r_tag1_b_id  <= '0;
            r_tag2_a_id  <= '0;
            r_tag2_b_id  <= '0;
        end else begin
            weA <= w_hit_a && bus.req_we[w_sel_a];
            reA <= w_hit_a && !bus.req_we[w_sel_a];
            weB <= w_hit_b && bus.req_we[w_sel_b];
            reB <= w_hit_b && !bus.req_we[w_sel_b];
            if (w_hit_a) begin
                addrA <= w_addr[w_sel_a];
                dinA  <= w_din[w_sel_a];
            end
            if (w_hit_b) begin
                addrB <= w_addr[w_sel_b];
                dinB  <= w_din[w_sel_b];
            end
            // Tags travel alongside the RAM access so the response lands with its read data.
            r_tag1_a_vld <= w_hit_a;
            r_tag1_b_vld <= w_hit_b;
            r_tag1_a_id  <= w_sel_a;
            r_tag1_b_id  <= w_sel_b;
            r_tag2_a_vld <= r_tag1_a_vld;
            r_tag2_b_vld <= r_tag1_b_vld;
            r_tag2_a_id  <= r_tag1_a_id;
            r_tag2_b_id  <= r_tag1_b_id;
        end
    end
endmodule

// File: tb/tb_ram_tdp_arbiter.sv
// Bench for ram_tdp_arbiter: behavioural write-first RAM, grant/response reference model, directed and random phases.
module tb_ram_tdp_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_tdp_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic              weA, reA, weB, reB;
    logic [ADDR_W-1:0] addrA, addrB;
    logic [DATA_W-1:0] dinA, dinB;
    logic [DATA_W-1:0] doutA = '0;
    logic [DATA_W-1:0] doutB = '0;

    ram_tdp_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .weA(weA), .reA(reA), .weB(weB), .reB(reB),
        .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
        .doutA(doutA), .doutB(doutB)
    );

    // Behavioural 1024x32 true-dual-port write-first RAM
    logic [DATA_W-1:0] ram_mem [DEPTH];
    initial foreach (ram_mem[i]) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (weA) begin
            ram_mem[addrA] <= dinA;
            doutA <= dinA;
        end else if (reA) begin
            doutA <= ram_mem[addrA];
        end
        if (weB) begin
            ram_mem[addrB] <= dinB;
            doutB <= dinB;
        end else if (reB) begin
            doutB <= ram_mem[addrB];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_ptr;
    int                cyc;
    int                q_due [NUM_REQ][$];
    logic [DATA_W-1:0] q_dat [NUM_REQ][$];

    int checks = 0;
    int errors = 0;

    logic [NUM_REQ-1:0]        obs_ready;
    logic [NUM_REQ-1:0]        obs_rsp_valid;
    logic [NUM_REQ*DATA_W-1:0] obs_rsp_data;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [ADDR_W-1:0] req_addr_of(input int i);
        return bus.req_addr[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] req_din_of(input int i);
        return bus.req_din[i*DATA_W +: DATA_W];
    endfunction

    // Expected grants: walk requesters in priority order, first pending wins A, next non-conflicting wins B
    function automatic logic [NUM_REQ-1:0] model_grant(output int f, output int s);
        logic [NUM_REQ-1:0] g;
        int start;
        g = '0;
        f = -1;
        s = -1;
        if (rst_n !== 1'b1) return g;
`ifdef RAM_TDP_ARB_STRICT_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (start + k) % NUM_REQ;
            if (bus.req_valid[i]) begin
                if (f < 0) f = i;
                else if (s < 0 && !(req_addr_of(i) == req_addr_of(f) && (bus.req_we[i] || bus.req_we[f]))) s = i;
            end
        end
        if (f >= 0) g[f] = 1'b1;
        if (s >= 0) g[s] = 1'b1;
        return g;
    endfunction

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_din[i*DATA_W +: DATA_W]  = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            q_due[i].delete();
            q_dat[i].delete();
        end
        m_ptr = 0;
    endtask

    // One clock: check at negedge, then advance the model across the posedge
    task automatic step();
        logic [NUM_REQ-1:0] exp_g;
        int f, s;
        int who [2];
        @(negedge clk);
        exp_g         = model_grant(f, s);
        obs_ready     = bus.req_ready;
        obs_rsp_valid = bus.rsp_valid;
        obs_rsp_data  = bus.rsp_data;
        chk($sformatf("req_ready@%0d", cyc), 64'(obs_ready), 64'(exp_g));
        for (int i = 0; i < NUM_REQ; i++) begin
            logic due;
            due = (q_due[i].size() > 0) && (q_due[i][0] == cyc);
            chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 64'(obs_rsp_valid[i]), 64'(due));
            if (due) begin
                chk($sformatf("rsp_data[%0d]@%0d", i, cyc), 64'(obs_rsp_data[i*DATA_W +: DATA_W]), 64'(q_dat[i][0]));
                void'(q_due[i].pop_front());
                void'(q_dat[i].pop_front());
            end
        end
        @(posedge clk);
        who[0] = f;
        who[1] = s;
        foreach (who[j]) begin
            if (who[j] >= 0 && !bus.req_we[who[j]]) begin
                q_due[who[j]].push_back(cyc + 2);
                q_dat[who[j]].push_back(ref_mem[req_addr_of(who[j])]);
            end
        end
        foreach (who[j]) begin
            if (who[j] >= 0 && bus.req_we[who[j]]) begin
                q_due[who[j]].push_back(cyc + 2);
                q_dat[who[j]].push_back(req_din_of(who[j]));
                ref_mem[req_addr_of(who[j])] = req_din_of(who[j]);
            end
        end
        if (f >= 0) m_ptr = (((s >= 0) ? s : f) + 1) % NUM_REQ;
        cyc++;
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    logic [NUM_REQ-1:0] grant_tbl [4];
    int wait_cnt [NUM_REQ];
    int max_wait;

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;
        cyc = 0;
        model_reset();
        idle_all();

        // 1: reset held with everyone requesting
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(16 * i + 1), '0);
        repeat (2) begin
            step();
            chk("reset_ready", 64'(obs_ready), 64'(0));
            chk("reset_ram_en", 64'({weA, reA, weB, reB}), 64'(0));
            chk("reset_rsp_valid", 64'(obs_rsp_valid), 64'(0));
        end
        rst_n = 1'b1;

        // 2: all four pending for four cycles, grants alternate in pairs
        grant_tbl[0] = 4'b0011;
        grant_tbl[1] = 4'b1100;
        grant_tbl[2] = 4'b0011;
        grant_tbl[3] = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rr_pair%0d", c), 64'(obs_ready), 64'(grant_tbl[c]));
            if (c == 0) begin
                chk("first_A", 64'({reA, weA, addrA}), 64'({1'b1, 1'b0, ADDR_W'(1)}));
                chk("first_B", 64'({reB, weB, addrB}), 64'({1'b1, 1'b0, ADDR_W'(17)}));
            end
        end
        idle_all();
        repeat (3) step();

        // 3: same-address write/read collision defers the reader
        set_req(0, 1'b1, 1'b1, 10'h0AB, 32'hDEADBEEF);
        set_req(1, 1'b1, 1'b0, 10'h0AB, '0);
        step();
        chk("hazard_block", 64'(obs_ready), 64'(4'b0001));
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();
        chk("hazard_next", 64'(obs_ready), 64'(4'b0010));
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
        chk("hazard_rd_valid", 64'(obs_rsp_valid[1]), 64'(1));
        chk("hazard_rd_data", 64'(obs_rsp_data[1*DATA_W +: DATA_W]), 64'(32'hDEADBEEF));

        // 4: pipelined write then read of the same address by one requester
        set_req(2, 1'b1, 1'b1, 10'h3FF, 32'h12345678);
        step();
        chk("pipe_wr_grant", 64'(obs_ready), 64'(4'b0100));
        set_req(2, 1'b1, 1'b0, 10'h3FF, '0);
        step();
        chk("pipe_rd_grant", 64'(obs_ready), 64'(4'b0100));
        set_req(2, 1'b0, 1'b0, '0, '0);
        step();
        chk("pipe_wr_rsp", 64'({obs_rsp_valid[2], obs_rsp_data[2*DATA_W +: DATA_W]}), 64'({1'b1, 32'h12345678}));
        step();
        chk("pipe_rd_rsp", 64'({obs_rsp_valid[2], obs_rsp_data[2*DATA_W +: DATA_W]}), 64'({1'b1, 32'h12345678}));

        // 5: reset right after two reads are accepted drops their responses, keeps RAM contents
        set_req(0, 1'b1, 1'b0, 10'h0AB, '0);
        set_req(3, 1'b1, 1'b0, 10'h3FF, '0);
        step();
        chk("pre_reset_grant", 64'(obs_ready), 64'(4'b1001));
        rst_n = 1'b0;
        model_reset();
        idle_all();
        repeat (3) begin
            step();
            chk("flushed_rsp", 64'(obs_rsp_valid), 64'(0));
        end
        rst_n = 1'b1;
        set_req(1, 1'b1, 1'b0, 10'h0AB, '0);
        set_req(3, 1'b1, 1'b0, 10'h3FF, '0);
        step();
        idle_all();
        step();
        step();
        chk("kept_0AB", 64'({obs_rsp_valid[1], obs_rsp_data[1*DATA_W +: DATA_W]}), 64'({1'b1, 32'hDEADBEEF}));
        chk("kept_3FF", 64'({obs_rsp_valid[3], obs_rsp_data[3*DATA_W +: DATA_W]}), 64'({1'b1, 32'h12345678}));

        // 6: random traffic, requests held until granted
        max_wait = 0;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        for (int c = 0; c < 2560; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || obs_ready[i] || c == 0) begin
                    if (c != 0 && bus.req_valid[i] && !obs_ready[i]) continue;
                    set_req(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                            ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
                end
            end
            step();
`ifdef RAM_TDP_ARB_STRICT_PRIO_EN
            if (bus.req_valid[0]) chk("prio0", 64'(obs_ready[0]), 64'(1));
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && !obs_ready[i]) wait_cnt[i]++;
                else if (bus.req_valid[i]) begin
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    wait_cnt[i] = 0;
                end
            end
        end
        idle_all();
        repeat (4) step();
        chk("max_wait_bound", 64'(max_wait <= NUM_REQ - 1), 64'(1));
        for (int i = 0; i < NUM_REQ; i++) chk($sformatf("drained[%0d]", i), 64'(q_due[i].size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
